// File: rtl/toggle_pulse_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : toggle_pulse_gen
// Purpose  : Programmable generator of single-cycle toggle-enable pulses for
//            the downstream toggle flip-flop stage. Issues one `t` pulse every
//            `period` cycles, either as a burst of `num_pulses` pulses or
//            continuously until `stop`.
// Ports    : clk         - clock, rising edge
//            reset       - asynchronous, active-high clear of all state
//            start       - begin request, accepted only in IDLE (and not
//                          together with stop)
//            stop        - abort request, effective in RUN
//            mode        - 0 = burst, 1 = continuous (sampled at start)
//            period      - pulse interval in cycles, 0 behaves as 1
//            num_pulses  - burst length (sampled at start)
//            t           - registered one-cycle toggle-enable pulse
//            busy        - high while RUN or DONE
//            done        - one-cycle burst-completion strobe
//            pulse_count - pulses issued since last accepted start
// Revision : 1.0 - initial release
// ============================================================================
module toggle_pulse_gen #(
  parameter int CNT_W   = 16,
  parameter int PULSE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [PULSE_W-1:0] num_pulses,
  output logic               t,
  output logic               busy,
  output logic               done,
  output logic [PULSE_W-1:0] pulse_count
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);
  localparam logic [PULSE_W-1:0] c_pulse_one = PULSE_W'(1);

  logic [1:0]         state_q,  state_d;
  logic [CNT_W-1:0]   timer_q,  timer_d;
  // Reload value is P_eff-1, so a period of 0 and 1 both reload with 0.
  logic [CNT_W-1:0]   reload_q, reload_d;
  logic               mode_q,   mode_d;
  logic [PULSE_W-1:0] num_q,    num_d;
  logic [PULSE_W-1:0] count_q,  count_d;
  logic               t_q,      t_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  logic [CNT_W-1:0]   w_reload_new;
  logic [PULSE_W-1:0] w_count_inc;

  assign w_reload_new = (period == '0) ? '0 : (period - c_cnt_one);
  // Natural wrap at 2^PULSE_W gives the continuous-mode rollover.
  assign w_count_inc  = count_q + c_pulse_one;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    num_d    = num_q;
    count_d  = count_q;
    t_d      = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      c_idle: begin
        if (start && !stop) begin
          mode_d   = mode;
          reload_d = w_reload_new;
          timer_d  = w_reload_new;
          num_d    = num_pulses;
          count_d  = '0;
          busy_d   = 1'b1;
          // A zero-length burst skips RUN so `t` never asserts.
          if (!mode && (num_pulses == '0)) begin
            state_d = c_done;
          end else begin
            state_d = c_run;
          end
        end
      end

      c_run: begin
        if (stop) begin
          // Abort wins over a pulse due on this same edge.
          state_d = c_idle;
          busy_d  = 1'b0;
        end else if (timer_q == '0) begin
          t_d     = 1'b1;
          timer_d = reload_q;
          count_d = w_count_inc;
          if (!mode_q && (w_count_inc == num_q)) begin
            state_d = c_done;
          end
        end else begin
          timer_d = timer_q - c_cnt_one;
        end
      end

      c_done: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = c_idle;
      end

      default: begin
        state_d = c_idle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= c_idle;
      timer_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      num_q    <= '0;
      count_q  <= '0;
      t_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      num_q    <= num_d;
      count_q  <= count_d;
      t_q      <= t_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign t           = t_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulse_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_pulse_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_toggle_pulse_gen
// Purpose  : Directed self-checking bench for toggle_pulse_gen. A default
//            instance covers burst, zero-period, zero-length, stop, reset and
//            start-conflict cases; a PULSE_W=3 instance covers counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_pulse_gen;

  logic        clk;
  logic        reset;
  logic        start, stop, mode;
  logic [15:0] period;
  logic [7:0]  num_pulses;
  logic        t, busy, done;
  logic [7:0]  pulse_count;

  logic        start2, stop2;
  logic [2:0]  num2;
  logic        t2, busy2, done2;
  logic [2:0]  pulse_count2;

  int n_tests;
  int n_fail;

  logic [15:0] tmask, dmask, bmask;
  int          npulse;

  toggle_pulse_gen #(.CNT_W(16), .PULSE_W(8)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .period      (period),
    .num_pulses  (num_pulses),
    .t           (t),
    .busy        (busy),
    .done        (done),
    .pulse_count (pulse_count)
  );

  toggle_pulse_gen #(.CNT_W(16), .PULSE_W(3)) u_dut_w3 (
    .clk         (clk),
    .reset       (reset),
    .start       (start2),
    .stop        (stop2),
    .mode        (mode),
    .period      (period),
    .num_pulses  (num2),
    .t           (t2),
    .busy        (busy2),
    .done        (done2),
    .pulse_count (pulse_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    mode       = 1'b0;
    period     = 16'd0;
    num_pulses = 8'd0;
    start2     = 1'b0;
    stop2      = 1'b0;
    num2       = 3'd0;

    // ---------------- reset state ----------------
    #12;
    check("rst_t",     t, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_count", pulse_count, 0);
    check("rst_busy2", busy2, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // ---------------- burst basic: period 3, N=4 ----------------
    period = 16'd3; num_pulses = 8'd4; mode = 1'b0; start = 1'b1;
    tick();                     // edge 0
    start = 1'b0;
    check("burst_busy_e0", busy, 1);
    check("burst_cnt_e0",  pulse_count, 0);
    tmask = '0; dmask = '0; bmask = '0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      tmask[i] = t; dmask[i] = done; bmask[i] = busy;
      if (i == 13) check("burst_cnt_e13", pulse_count, 4);
    end
    check("burst_t_mask",    tmask, 16'h1248);
    check("burst_done_mask", dmask, 16'h2000);
    check("burst_busy_mask", bmask, 16'h1FFE);

    // ---------------- period zero: N=3 ----------------
    period = 16'd0; num_pulses = 8'd3; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tmask = '0; dmask = '0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      tmask[i] = t; dmask[i] = done;
    end
    check("p0_t_mask",    tmask, 16'h000E);
    check("p0_done_mask", dmask, 16'h0010);
    check("p0_count",     pulse_count, 3);

    // ---------------- zero-length burst ----------------
    period = 16'd5; num_pulses = 8'd0; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("n0_busy_e0", busy, 1);
    tmask = '0; dmask = '0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      tmask[i] = t; dmask[i] = done;
    end
    check("n0_t_mask",    tmask, 16'h0000);
    check("n0_done_mask", dmask, 16'h0002);
    check("n0_count",     pulse_count, 0);

    // ---------------- continuous + stop on 5th pulse edge ----------------
    period = 16'd2; num_pulses = 8'd1; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tmask = '0; dmask = '0; npulse = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 10) stop = 1'b1;
      tick();
      stop = 1'b0;
      tmask[i] = t; dmask[i] = done;
      if (t) npulse++;
      if (i == 10) begin
        check("stop_t_e10",    t, 0);
        check("stop_busy_e10", busy, 0);
      end
    end
    check("stop_t_mask",    tmask, 16'h0154);
    check("stop_npulse",    npulse, 4);
    check("stop_done_mask", dmask, 16'h0000);
    check("stop_count",     pulse_count, 4);

    // ---------------- continuous wrap on PULSE_W=3 ----------------
    period = 16'd1; mode = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tmask = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      tmask[i] = t2;
      if (i == 7)  check("wrap_cnt_e7",  pulse_count2, 7);
      if (i == 8)  check("wrap_cnt_e8",  pulse_count2, 0);
      if (i == 9)  check("wrap_cnt_e9",  pulse_count2, 1);
      if (i == 10) check("wrap_cnt_e10", pulse_count2, 2);
    end
    check("wrap_t_mask", tmask, 16'h07FE);
    check("wrap_busy",   busy2, 1);
    stop2 = 1'b1;
    tick();
    stop2 = 1'b0;
    check("wrap_busy_stopped", busy2, 0);

    // ---------------- async reset mid-burst ----------------
    period = 16'd2; num_pulses = 8'd5; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    check("rmid_pre_t",   t, 1);
    check("rmid_pre_cnt", pulse_count, 2);
    #2;
    reset = 1'b1;
    #1;
    check("rmid_t",     t, 0);
    check("rmid_busy",  busy, 0);
    check("rmid_done",  done, 0);
    check("rmid_count", pulse_count, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    check("rmid_post_busy", busy, 0);
    check("rmid_post_t",    t, 0);

    // ---------------- start while busy is ignored ----------------
    period = 16'd4; num_pulses = 8'd2; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tmask = '0; dmask = '0;
    for (int i = 1; i <= 11; i++) begin
      if (i == 2) begin
        start = 1'b1; period = 16'd1; num_pulses = 8'd7; mode = 1'b1;
      end
      tick();
      start = 1'b0;
      tmask[i] = t; dmask[i] = done;
    end
    check("sbusy_t_mask",    tmask, 16'h0110);
    check("sbusy_done_mask", dmask, 16'h0200);
    check("sbusy_count",     pulse_count, 2);

    // ---------------- start and stop together in IDLE ----------------
    period = 16'd1; num_pulses = 8'd3; mode = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    tmask = '0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      tmask[i] = t;
    end
    check("ss_t_mask", tmask, 16'h0000);
    check("ss_count",  pulse_count, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/toggle_pulse_gen.md
# toggle_pulse_gen

Programmable generator of single-cycle toggle-enable pulses, sitting directly upstream of the toggle flip-flop stage and driving its `t` input. It produces one `t` pulse every `period` clock cycles, either as a fixed-length burst or continuously until stopped. It reports progress through `busy`, `done` and a pulse counter.

## Interface
- `CNT_W`, default 16: width of the `period` input and of the internal interval timer.
- `PULSE_W`, default 8: width of the `num_pulses` input and of the `pulse_count` output.

- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state and outputs.
- `start`  input  1  request to begin; accepted only in IDLE.
- `stop`  input  1  abort request; effective in RUN.
- `mode`  input  1  0 = burst (`num_pulses` pulses then finish), 1 = continuous.
- `period`  input  CNT_W  interval between pulses, in cycles; 0 is treated as 1.
- `num_pulses`  input  PULSE_W  burst length; ignored in continuous mode.
- `t`  output  1  registered toggle-enable pulse, one cycle wide.
- `busy`  output  1  high while in RUN or DONE.
- `done`  output  1  one-cycle completion strobe, burst mode only.
- `pulse_count`  output  PULSE_W  pulses issued since the last accepted start.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- Reset values: state IDLE; `t`, `busy`, `done` = 0; `pulse_count` = 0; timer = 0.
- **IDLE**
  - `start`=1 and `stop`=0 at an edge accepts the start:
    - latch `mode`, `P_eff = (period==0 ? 1 : period)` and `num_pulses`;
    - timer <= P_eff-1; `pulse_count` <= 0; `busy` <= 1; state <= RUN.
  - Burst mode with `num_pulses`=0: go straight to DONE instead of RUN.
  - `start` and `stop` both high in IDLE: start is ignored.
- **RUN**, at each edge, in priority order:
  - `stop`=1: state <= IDLE; `t` <= 0; `busy` <= 0; `done` stays 0; `pulse_count` holds.
  - Else timer==0: `t` <= 1; timer <= P_eff-1; `pulse_count` <= `pulse_count`+1.
    - Burst mode and `pulse_count`+1 == latched N: state <= DONE.
  - Else: `t` <= 0; timer <= timer-1.
- **DONE**, one cycle: `t` <= 0; `done` <= 1; `busy` <= 0; state <= IDLE.
  - `stop` has no effect in DONE.
- `done` is cleared on the following edge, so it is exactly one cycle wide.
- `start` while `busy`=1 is ignored. `period`, `num_pulses` and `mode` are sampled only at start acceptance.
- Continuous mode: `pulse_count` wraps from 2^PULSE_W-1 to 0 and the block keeps running.
- `pulse_count` holds its final value in IDLE until the next accepted start.

## Timing
- Start accepted at edge k:
  - `busy` is high after edge k;
  - first `t` is high in the cycle after edge k+P_eff;
  - subsequent `t` pulses are exactly P_eff cycles apart.
- P_eff=1: `t` is high every cycle while in RUN.
- Burst of N pulses: the last `t` is high after edge k+N·P_eff; `done` is high, and `busy` low, after edge k+N·P_eff+1.
- Burst with N=0: `done` is high after edge k+1; `t` never asserts.
- `stop` sampled at edge j: `t` and `busy` are low after edge j, even if edge j would have issued a pulse.
- Earliest restart: a new start can be accepted at the edge after `busy` falls (one idle cycle minimum after DONE).
- `reset` asserted mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- Burst basic: `period`=3, `num_pulses`=4, `mode`=0, start at edge 0.
  - Required: `t` high after edges 3, 6, 9, 12; `done` high after edge 13 only; `pulse_count`=4; `busy` low after edge 13.
- Period zero: `period`=0, `num_pulses`=3, burst.
  - Required: `t` high after edges 1, 2, 3; `done` high after edge 4.
- Zero-length burst: `num_pulses`=0, `mode`=0.
  - Required: `t` never high; `done` high for one cycle after edge 1; `pulse_count`=0.
- Continuous plus stop: `period`=2, `mode`=1, stop asserted at the edge where the 5th pulse is due.
  - Required: exactly 4 pulses seen; `t`=0 and `busy`=0 after the stop edge; `done` never high; `pulse_count`=4.
- Continuous wrap: `PULSE_W`=3, `period`=1, run 10 cycles.
  - Required: `pulse_count` sequence goes 7 → 0 → 1 → 2; `t` high every cycle.
- Reset mid-run and start conflicts:
  - async `reset` pulse between edges during a burst: `t`, `busy`, `done`, `pulse_count` go to 0 immediately;
  - `start` while busy: ignored;
  - `start` and `stop` together in IDLE: no start.
